// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: converts a binary score to BCD, commits it at frame start,
// and drives the scoreboard sprite address, read enable and digit select from
// the pixel counters.
module scoreboard_ctrl #(
  parameter int DIGITS  = 4,
  parameter int SCORE_W = 14,
  parameter int DIG_W   = 32,
  parameter int DIG_H   = 32,
  parameter int X0      = 16,
  parameter int Y0      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  input  logic [10:0]        hcount,
  input  logic [10:0]        vcount,
  output logic [9:0]         addr,
  output logic               rden,
  output logic [9:0]         onehot,
  output logic               pix_en
);
  localparam int BW   = 4 * DIGITS;
  localparam int MAXV = 10 ** DIGITS - 1;
  localparam int CW   = $clog2(SCORE_W + 1);
  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
  state_t state_q, state_d;
  logic [SCORE_W-1:0] shreg_q, shreg_d, pval_q, pval_d, sat;
  logic [BW-1:0] bcd_q, bcd_d, disp_bcd_q, disp_bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, fs;
  logic in_r, blk, nz, vis, vis_q, vis2_q, pix_q;
  logic [10:0] dx, dy, k, col;
  logic [9:0] addr_n, addr_q, onehot_q;
  logic [3:0] dig, dig_q;
  assign sat  = (32'(score) > MAXV) ? SCORE_W'(MAXV) : score;
  assign fs   = (hcount == 11'd0) && (vcount == 11'd0);
  assign busy = (state_q != IDLE);
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    disp_bcd_d = disp_bcd_q;
    pend_d     = pend_q | (score_valid && state_q != IDLE);
    pval_d     = (score_valid && state_q != IDLE) ? sat : pval_q;
    case (state_q)
      IDLE: if (score_valid) begin
        shreg_d = sat;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        {bcd_d, shreg_d} = {adj, shreg_q} << 1;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(SCORE_W - 1)) ? HOLD : CONV;
      end
      HOLD: if (fs) begin
        disp_bcd_d = bcd_q;
        state_d    = pend_d ? CONV : IDLE;
        // a strobe in this very cycle is already folded into pend_d/pval_d
        if (pend_d) begin
          shreg_d = pval_d;
          bcd_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign in_r = (hcount >= 11'(X0)) && (hcount < 11'(X0 + DIGITS * DIG_W)) &&
                (vcount >= 11'(Y0)) && (vcount < 11'(Y0 + DIG_H));
  assign dx     = hcount - 11'(X0);
  assign dy     = vcount - 11'(Y0);
  assign k      = dx / 11'(DIG_W);
  assign col    = dx % 11'(DIG_W);
  assign addr_n = 10'(dy * 11'(DIG_W) + col);
  always_comb begin
    dig = '0;
    blk = 1'b0;
    nz  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      nz = nz | (disp_bcd_q[BW-4-4*i +: 4] != 4'd0);
      if (k == 11'(i)) begin
        dig = disp_bcd_q[BW-4-4*i +: 4];
        blk = !nz && (i != DIGITS - 1);
      end
    end
  end
  assign vis = in_r && !blk;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      disp_bcd_q <= '0;
      pend_q     <= 1'b0;
      pval_q     <= '0;
      addr_q     <= '0;
      dig_q      <= '0;
      vis_q      <= 1'b0;
      vis2_q     <= 1'b0;
      onehot_q   <= '0;
      pix_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      disp_bcd_q <= disp_bcd_d;
      pend_q     <= pend_d;
      pval_q     <= pval_d;
      addr_q     <= addr_n;
      dig_q      <= dig;
      vis_q      <= vis;
      vis2_q     <= vis_q;
      onehot_q   <= vis_q ? 10'(1) << dig_q : '0;
      pix_q      <= vis2_q;
    end
  end
  assign addr   = addr_q;
  assign rden   = vis_q;
  assign onehot = onehot_q;
  assign pix_en = pix_q;
endmodule

// File: doc/scoreboard_ctrl.md
# scoreboard_ctrl

Sequencing controller for the digit-sprite scoreboard datapath. Accepts a binary score and converts it to BCD with a multi-cycle double-dabble engine. Commits the new digits only at frame start, so no tearing. Drives the scoreboard's shared `addr`, `rden` and `onehot` inputs from the VGA pixel counters, and emits a pixel-enable aligned with `scoreboard_data`. Sits between game logic and the scoreboard instance in the video pipeline.

## Interface
Parameters:
- `DIGITS`, 4: number of rendered decimal digits (score range 0..10^DIGITS-1).
- `SCORE_W`, 14: binary score width.
- `DIG_W`, 32: sprite width in pixels. `DIG_W*DIG_H` must be ≤ 1024.
- `DIG_H`, 32: sprite height in pixels.
- `X0`, 16: left edge of the scoreboard region (pixels).
- `Y0`, 16: top edge of the scoreboard region (lines).

Ports:
- `clk` in 1: pixel clock; one clock domain only.
- `rst` in 1: asynchronous, active-high reset.
- `score` in SCORE_W: binary score, sampled when `score_valid`=1.
- `score_valid` in 1: single-cycle load strobe.
- `busy` out 1: high whenever the FSM is not IDLE.
- `hcount` in 11: current pixel x.
- `vcount` in 11: current pixel y.
- `addr` out 10: sprite ROM address to the scoreboard.
- `rden` out 1: ROM read enable to the scoreboard.
- `onehot` out 10: digit-value select to the scoreboard.
- `pix_en` out 1: high when `scoreboard_data` is a valid glyph pixel.

## Operation
FSM states: IDLE, CONV, HOLD.
- IDLE:
  - `score_valid`=1 → latch `score` into `shreg`, clear the BCD accumulator, go to CONV.
  - A score above 10^DIGITS-1 is saturated to 10^DIGITS-1 (9999 by default) before latching.
- CONV: exactly SCORE_W cycles of double-dabble.
  - Each cycle: add 3 to every BCD nibble ≥5, then shift {bcd, shreg} left by 1.
  - After SCORE_W cycles → HOLD.
- HOLD: wait for frame start (`hcount`=0 and `vcount`=0).
  - On frame start: copy the accumulator to `disp_bcd` (DIGITS×4 bits).
  - Then: if the pending flag is set → reload from the pending register and go to CONV; otherwise go to IDLE.
- `score_valid` during CONV or HOLD: store the saturated value in the pending register and set the pending flag. A later strobe overwrites the earlier one; only the last value is kept. The conversion in flight is never aborted.

Render path (runs in every state; always uses `disp_bcd`):
- Inside region: `X0` ≤ `hcount` < `X0+DIGITS*DIG_W` and `Y0` ≤ `vcount` < `Y0+DIG_H`.
- Digit index k = (`hcount`-X0)/DIG_W. k=0 is the most significant digit.
- ROM address = (`vcount`-Y0)*DIG_W + (`hcount`-X0)%DIG_W.
- Leading-zero blanking: digit k is blanked if it is 0 and all more significant digits are 0. The least significant digit is never blanked.
- A blanked digit, or any pixel outside the region, gives `rden`=0, `onehot`=0 and `pix_en`=0.
  - Required because the scoreboard holds its output when `onehot`=0.

## Timing
- Reset: state IDLE, `busy`=0, `addr`=0, `rden`=0, `onehot`=0, `pix_en`=0, `disp_bcd`=0, pending flag=0.
  - Display after reset shows a single "0".
  - Reset mid-CONV or mid-HOLD discards the conversion in flight and any pending score.
- Pipeline, for counters presented in cycle t:
  - Stage 1, edge t+1: register `addr`, `rden`, digit value, and the visible flag.
  - Stage 2, edge t+2: register `onehot` = 1<<digit value (0 if not visible). The scoreboard ROM samples `addr` at the same edge.
  - Edge t+3: the scoreboard registers its data. `pix_en` is the visible flag delayed 3 edges.
  - Result: `pix_en` and `scoreboard_data` are valid together, 3 cycles after the counters.
- Conversion latency: `busy` rises the cycle after `score_valid`.
  - IDLE→HOLD takes SCORE_W+1 edges.
  - The commit happens on the first frame-start cycle at or after HOLD entry, and `busy` falls on that edge (if no pending score).
- Frame start coinciding with the last CONV cycle: not committed. The controller waits for the next frame.
- `score_valid` arriving in the same cycle as the HOLD commit: captured as pending; CONV restarts immediately.
- `disp_bcd` changes only at frame start, so all digits of one frame come from one score.

## Test plan
- Reset → all outputs 0. Pixel (X0+3*DIG_W, Y0) = (112,16) → after 3 cycles, `onehot`=10'b0000000001 and `pix_en`=1. Digits 0–2 give `pix_en`=0.
- `score`=1234 strobe → `busy`=1 for 14 CONV cycles, then HOLD. At the next (0,0), `disp_bcd`=16'h1234 and `busy` falls.
- Score 1234 displayed; pixel (X0+DIG_W+5, Y0+2) = (53,18) → `addr`=2*32+5=69 and `onehot`=10'b0000000100 (digit 2). `onehot` lags `addr` by 1 cycle; `pix_en` lags the counters by 3 cycles.
- `score`=7 → digits 0–2 blanked (`rden`=0, `onehot`=0). Digit 3 gives `onehot`=10'b0010000000.
- `score`=12000 → `disp_bcd`=16'h9999. Strobes of 5 then 42 during CONV → after the first commit, CONV restarts and the next frame shows 42; 5 is never displayed.
- `rst` pulsed mid-CONV with a pending score → IDLE, `busy`=0, `disp_bcd`=0, pending flag cleared.
